ct_fcnvt_htos_pipe: RTL and testbench

CT_FCNVT_HTOS_PIPE -- requirements
Module: ct_fcnvt_htos_pipe

---
 rtl/ct_fcnvt_htos_pipe_if.sv | 40 ++++
 rtl/ct_fcnvt_htos_pipe.sv | 138 +++++++++++++
 tb/tb_ct_fcnvt_htos_pipe.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/ct_fcnvt_htos_pipe_if.sv
// FP16->FP32 conversion pipe interface: operand in, normalizer side
// channel, and EX3 result out.
interface ct_fcnvt_htos_pipe_if;
   logic        ex1_htos_vld;
   logic [15:0] ex1_htos_src;
   logic        htos_pipe_stall;
   logic        htos_pipe_flush;
   logic [9:0]  htos_sh_src;
   logic [5:0]  htos_sh_cnt;
   logic [10:0] htos_sh_f_v;
   logic        ex3_htos_vld;
   logic [31:0] ex3_htos_result;
   logic [4:0]  ex3_htos_fflags;

   modport master (
      output ex1_htos_vld,
      output ex1_htos_src,
      output htos_pipe_stall,
      output htos_pipe_flush,
      output htos_sh_cnt,
      output htos_sh_f_v,
      input  htos_sh_src,
      input  ex3_htos_vld,
      input  ex3_htos_result,
      input  ex3_htos_fflags
   );

   modport slave (
      input  ex1_htos_vld,
      input  ex1_htos_src,
      input  htos_pipe_stall,
      input  htos_pipe_flush,
      input  htos_sh_cnt,
      input  htos_sh_f_v,
      output htos_sh_src,
      output ex3_htos_vld,
      output ex3_htos_result,
      output ex3_htos_fflags
   );
endinterface

// File: rtl/ct_fcnvt_htos_pipe.sv
// Exact FP16 -> FP32 conversion, EX1 classify, EX2/EX3 registered.
// Denormal operands are normalized by an external shifter.
module ct_fcnvt_htos_pipe (
   input logic             forever_cpuclk,
   input logic             cpurst_b,
   ct_fcnvt_htos_pipe_if.slave io
);

   typedef enum logic [1:0] {
      CLS_ZERO,
      CLS_FIN,
      CLS_INF,
      CLS_NAN
   } cls_e;

   typedef struct packed {
      cls_e        cls;
      logic        sign;
      logic [7:0]  exp;
      logic [22:0] frac;
      logic        nv;
   } ex2_t;

   logic [4:0]  ex1_exp;
   logic [9:0]  ex1_frac;
   logic        ex1_exp_zero;
   logic        ex1_exp_max;
   logic        ex1_frac_zero;
   logic [7:0]  ex1_sh_exp;
   logic        unused_sh_msb;
   ex2_t        ex1_d;

   logic        ex2_vld;
   ex2_t        ex2_q;
   logic [31:0] ex2_res;
   logic [4:0]  ex2_flg;

   logic        ex3_vld;
   logic [31:0] ex3_res;
   logic [4:0]  ex3_flg;

   logic        stall;
   logic        flush;

   assign stall = io.htos_pipe_stall;
   assign flush = io.htos_pipe_flush;

   assign ex1_exp       = io.ex1_htos_src[14:10];
   assign ex1_frac      = io.ex1_htos_src[9:0];
   assign ex1_exp_zero  = ex1_exp == 5'd0;
   assign ex1_exp_max   = &ex1_exp;
   assign ex1_frac_zero = ex1_frac == 10'd0;

   assign io.htos_sh_src = ex1_frac;
   assign unused_sh_msb  = io.htos_sh_f_v[10];

   // normalizer count is the unbiased exponent (-15..-24)
   assign ex1_sh_exp = 8'd127
                     + {{2{io.htos_sh_cnt[5]}},
                        io.htos_sh_cnt};

   always_comb begin
      ex1_d      = '0;
      ex1_d.sign = io.ex1_htos_src[15];
      unique case (1'b1)
         ex1_exp_zero && ex1_frac_zero: begin
            ex1_d.cls = CLS_ZERO;
         end
         ex1_exp_zero && !ex1_frac_zero: begin
            ex1_d.cls  = CLS_FIN;
            ex1_d.exp  = ex1_sh_exp;
            ex1_d.frac = {io.htos_sh_f_v[9:0], 13'b0};
         end
         ex1_exp_max && ex1_frac_zero: begin
            ex1_d.cls = CLS_INF;
         end
         ex1_exp_max && !ex1_frac_zero: begin
            ex1_d.cls = CLS_NAN;
            ex1_d.nv  = !ex1_frac[9];
         end
         default: begin
            ex1_d.cls  = CLS_FIN;
            ex1_d.exp  = {3'b0, ex1_exp} + 8'd112;
            ex1_d.frac = {ex1_frac, 13'b0};
         end
      endcase
   end

   always_comb begin
      ex2_res = 32'h0;
      unique case (ex2_q.cls)
         CLS_ZERO: ex2_res = {ex2_q.sign, 31'b0};
         CLS_FIN:  ex2_res = {ex2_q.sign, ex2_q.exp,
                              ex2_q.frac};
         CLS_INF:  ex2_res = {ex2_q.sign, 8'hff, 23'b0};
         CLS_NAN:  ex2_res = 32'h7fc00000;
         default:  ex2_res = 32'h0;
      endcase
      ex2_flg = {ex2_q.nv, 4'b0};
   end

   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         ex2_vld <= 1'b0;
         ex3_vld <= 1'b0;
      end else if (flush) begin
         ex2_vld <= 1'b0;
         ex3_vld <= 1'b0;
      end else if (!stall) begin
         ex2_vld <= io.ex1_htos_vld;
         ex3_vld <= ex2_vld;
      end
   end

   // data flops only toggle when a live operand moves
   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         ex2_q <= '0;
      end else if (io.ex1_htos_vld && !stall) begin
         ex2_q <= ex1_d;
      end
   end

   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         ex3_res <= 32'h0;
         ex3_flg <= 5'h0;
      end else if (ex2_vld && !stall) begin
         ex3_res <= ex2_res;
         ex3_flg <= ex2_flg;
      end
   end

   assign io.ex3_htos_vld    = ex3_vld;
   assign io.ex3_htos_result = ex3_res;
   assign io.ex3_htos_fflags = ex3_flg;

endmodule

// File: tb/tb_ct_fcnvt_htos_pipe.sv
// Scoreboard bench for the FP16 -> FP32 conversion pipe, with a
// behavioural normalizer and an arithmetic reference conversion.
module tb_ct_fcnvt_htos_pipe;

   typedef struct {
      logic [31:0] res;
      logic [4:0]  flg;
      int          edges;
   } exp_t;

   logic clk;
   logic rst_n;

   ct_fcnvt_htos_pipe_if io ();

   ct_fcnvt_htos_pipe dut (
      .forever_cpuclk (clk),
      .cpurst_b       (rst_n),
      .io             (io.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   n_chk  = 0;
   int   n_fail = 0;
   exp_t q[$];
   bit   adv = 1'b0;
   logic [31:0] last_res = '0;
   logic [4:0]  last_flg = '0;

   // value = m * 2^e, renormalized until m sits in [2^23, 2^24)
   function automatic exp_t ref_htos(logic [15:0] h);
      exp_t r;
      int   e;
      int   f;
      int   m;
      int   ex;
      int   b;
      e = int'(h[14:10]);
      f = int'(h[9:0]);
      r.flg   = 5'h0;
      r.edges = 1;
      if (e == 31) begin
         if (f == 0) begin
            r.res = {h[15], 8'hff, 23'h0};
         end else begin
            r.res = 32'h7fc00000;
            if (f < 512) r.flg = 5'h10;
         end
      end else if (e == 0 && f == 0) begin
         r.res = {h[15], 31'h0};
      end else begin
         m  = (e == 0) ? f : 1024 + f;
         ex = (e == 0) ? -24 : e - 25;
         while (m < (1 << 23)) begin
            m  = m * 2;
            ex = ex - 1;
         end
         b     = ex + 23 + 127;
         r.res = {h[15], b[7:0], m[22:0]};
      end
      return r;
   endfunction

   // external leading-one normalizer
   always_comb begin
      int p;
      p = 0;
      for (int i = 0; i < 10; i++)
         if (io.htos_sh_src[i]) p = i;
      io.htos_sh_cnt = 6'(p - 24);
      io.htos_sh_f_v = 11'({1'b0, io.htos_sh_src} << (10 - p));
   end

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, req);
      end
   endtask

   always @(negedge rst_n) q.delete();

   always @(posedge clk) begin
      if (rst_n) begin
         if (io.htos_pipe_flush) begin
            q.delete();
         end else if (!io.htos_pipe_stall) begin
            foreach (q[i]) q[i].edges++;
            if (io.ex1_htos_vld)
               q.push_back(ref_htos(io.ex1_htos_src));
         end
      end
      adv = rst_n && !io.htos_pipe_stall
            && !io.htos_pipe_flush;
   end

   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         chk("sh_src", 32'(io.htos_sh_src),
             32'(io.ex1_htos_src[9:0]));
         if (io.ex3_htos_vld) begin
            if (adv) begin
               if (q.size() == 0) begin
                  chk("unexpected_out", 32'(io.ex3_htos_vld), 32'd0);
               end else begin
                  e = q.pop_front();
                  chk("result", io.ex3_htos_result, e.res);
                  chk("fflags", 32'(io.ex3_htos_fflags), 32'(e.flg));
                  chk("latency", 32'(e.edges), 32'd2);
               end
               last_res = io.ex3_htos_result;
               last_flg = io.ex3_htos_fflags;
            end else begin
               chk("hold_result", io.ex3_htos_result, last_res);
               chk("hold_fflags", 32'(io.ex3_htos_fflags),
                   32'(last_flg));
            end
         end
      end
   end

   task automatic step(input logic v, input logic [15:0] s,
                       input logic st, input logic fl);
      @(posedge clk);
      #1;
      io.ex1_htos_vld    = v;
      io.ex1_htos_src    = s;
      io.htos_pipe_stall = st;
      io.htos_pipe_flush = fl;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 16'h0, 1'b0, 1'b0);
   endtask

   logic [15:0] dir [8] = '{16'h3c00, 16'hfc00, 16'h0001,
                            16'h03ff, 16'h8200, 16'h7c01,
                            16'hfe00, 16'h8000};

   initial begin
      logic [15:0] cs;
      logic        cv;
      logic        cst;
      int          r;
      rst_n              = 1'b0;
      io.ex1_htos_vld    = 1'b0;
      io.ex1_htos_src    = 16'h0;
      io.htos_pipe_stall = 1'b0;
      io.htos_pipe_flush = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_vld", 32'(io.ex3_htos_vld), 32'd0);
      chk("rst_result", io.ex3_htos_result, 32'h0);
      chk("rst_fflags", 32'(io.ex3_htos_fflags), 32'd0);
      #2 rst_n = 1'b1;
      idle(2);

      foreach (dir[i]) step(1'b1, dir[i], 1'b0, 1'b0);
      idle(4);

      step(1'b1, 16'h4000, 1'b0, 1'b0);
      step(1'b1, 16'hc500, 1'b0, 1'b0);
      step(1'b1, 16'h0123, 1'b1, 1'b0);
      step(1'b1, 16'h0123, 1'b1, 1'b0);
      step(1'b1, 16'h0123, 1'b0, 1'b0);
      idle(4);

      for (int k = 0; k < 2; k++) begin
         step(1'b1, 16'h3555, 1'b0, 1'b0);
         step(1'b1, 16'h7c00, 1'b0, 1'b0);
         step(1'b1, 16'h7d00, k[0], 1'b1);
         step(1'b0, 16'h0, 1'b0, 1'b0);
         @(negedge clk);
         chk("flush_vld", 32'(io.ex3_htos_vld), 32'd0);
         idle(4);
      end

      step(1'b1, 16'h3c00, 1'b0, 1'b0);
      step(1'b1, 16'h8001, 1'b0, 1'b0);
      step(1'b0, 16'h0, 1'b0, 1'b0);
      #3 rst_n = 1'b0;
      #1;
      chk("arst_vld", 32'(io.ex3_htos_vld), 32'd0);
      chk("arst_result", io.ex3_htos_result, 32'h0);
      chk("arst_fflags", 32'(io.ex3_htos_fflags), 32'd0);
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      idle(5);

      cv  = 1'b0;
      cs  = 16'h0;
      cst = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (!(cst && cv)) begin
            cv = ($urandom_range(0, 9) < 7);
            r  = int'($urandom_range(0, 4));
            cs = 16'($urandom);
            if (r == 0) cs[14:10] = 5'd0;
            if (r == 1) cs[14:10] = 5'd31;
            if ($urandom_range(0, 7) == 0) cs[9:0] = 10'd0;
         end
         cst = ($urandom_range(0, 9) < 2);
         step(cv, cs, cst, ($urandom_range(0, 19) == 0));
      end
      idle(6);
      @(negedge clk);
      chk("drain_empty", 32'(q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
